// File: rtl/nonce_pkg.sv
// Shared widths and the golden-nonce back-offset used by the nonce controller.
package nonce_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam int unsigned OVF_W   = 8;

  // Nonce that hasher `chan` was working on when its match strobe fired:
  // the issue counter has moved on by latency*hashers since that nonce left.
  function automatic logic [NONCE_W-1:0] golden_nonce(
    input logic [NONCE_W-1:0] base,
    input int unsigned        latency,
    input int unsigned        hashers,
    input int unsigned        chan
  );
    logic [NONCE_W-1:0] back;
    back = NONCE_W'(latency * hashers);
    return base - back + NONCE_W'(chan);
  endfunction

endpackage

// File: rtl/golden_fifo.sv
// Small synchronous FIFO for golden nonces; head is presented combinationally,
// and reads as zero when empty. A push into a full FIFO is accepted only if a
// pop happens in the same cycle.
module golden_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/nonce_ctrl.sv
// Nonce issue counter plus golden-nonce collection: per-hasher pending
// registers, a fixed-priority arbiter and an output FIFO.
module nonce_ctrl
  import nonce_pkg::*;
#(
  parameter int unsigned NUM_HASHERS  = 2,
  parameter int unsigned LOOP_LATENCY = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   load,
  input  logic [NONCE_W-1:0]     load_nonce,
  input  logic [NUM_HASHERS-1:0] match,
  output logic [NONCE_W-1:0]     base_nonce,
  output logic                   gn_valid,
  output logic [NONCE_W-1:0]     gn_data,
  input  logic                   gn_ready,
  output logic [OVF_W-1:0]       overflow_count,
  output logic                   wrapped
);

  logic [NONCE_W-1:0]     base_q;
  logic                   wrapped_q;
  logic [NONCE_W:0]       base_sum;

  logic [NUM_HASHERS-1:0] pend_q;
  logic [NUM_HASHERS-1:0] pend_d;
  logic [NONCE_W-1:0]     pend_data_q [NUM_HASHERS];
  logic [NONCE_W-1:0]     pend_data_d [NUM_HASHERS];

  logic [OVF_W-1:0]       ovf_q;
  logic [OVF_W-1:0]       ovf_d;
  logic [OVF_W-1:0]       drop_cnt;
  logic [OVF_W:0]         ovf_sum;

  logic [NUM_HASHERS-1:0] grant;
  logic                   found;
  logic [NUM_HASHERS-1:0] drain;
  logic [NONCE_W-1:0]     push_data;
  logic                   push_en;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign base_nonce     = base_q;
  assign wrapped        = wrapped_q;
  assign overflow_count = ovf_q;
  assign gn_valid       = ~fifo_empty;
  assign pop            = gn_valid & gn_ready;

  // 33-bit add exposes the carry that signals a wrap past 2^32.
  assign base_sum = {1'b0, base_q} + (NONCE_W + 1)'(NUM_HASHERS);

  // Issue counter: reset, then load, then advance unless halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      wrapped_q <= 1'b0;
    end else if (load) begin
      base_q    <= load_nonce;
      wrapped_q <= 1'b0;
    end else if (!halt) begin
      base_q    <= base_sum[NONCE_W-1:0];
      wrapped_q <= base_sum[NONCE_W];
    end else begin
      wrapped_q <= 1'b0;
    end
  end

  // Find-first-set arbiter over pending channels, lowest index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_HASHERS); k++) begin
      if (pend_q[k] && !found) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Grant is one-hot, so OR-ing the gated data selects the winner.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < int'(NUM_HASHERS); k++) begin
      if (grant[k]) push_data = push_data | pend_data_q[k];
    end
  end

  // Load flushes the FIFO in the same edge, so nothing may be pushed then.
  assign push_en = found & (~fifo_full | pop) & ~load;
  assign drain   = push_en ? grant : '0;

  // Pending capture, drain and drop accounting.
  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    drop_cnt    = '0;
    for (int k = 0; k < int'(NUM_HASHERS); k++) begin
      if (drain[k]) pend_d[k] = 1'b0;
      if (match[k]) begin
        if (pend_q[k] && !drain[k]) begin
          drop_cnt = drop_cnt + OVF_W'(1);
        end else begin
          pend_d[k]      = 1'b1;
          pend_data_d[k] = golden_nonce(base_q, LOOP_LATENCY, NUM_HASHERS, k);
        end
      end
    end
    if (load) begin
      pend_d   = '0;
      drop_cnt = '0;
    end
  end

  // Saturating drop counter.
  always_comb begin
    ovf_sum = {1'b0, ovf_q} + {1'b0, drop_cnt};
    ovf_d   = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
  end

  // Pending channel state and overflow count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      ovf_q  <= '0;
      for (int k = 0; k < int'(NUM_HASHERS); k++) pend_data_q[k] <= '0;
    end else begin
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      pend_data_q <= pend_data_d;
    end
  end

  golden_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (load),
    .push  (push_en),
    .pop   (pop),
    .wdata (push_data),
    .rdata (gn_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
